// File: rtl/aclk_pkg.sv
// -----------------------------------------------------------------------------
// aclk_pkg
// Shared definitions for the alarm-clock key entry slice:
//   NOKEY          keypad code meaning "no key pressed"
//   state_t        key entry FSM state encoding
//   time limits    largest legal value of each key register digit
//   is_digit       true for keypad codes 0-9
//   is_valid_time  HH:MM range check on four BCD digits (00:00 .. 23:59)
// -----------------------------------------------------------------------------
package aclk_pkg;

    localparam logic [3:0] NOKEY          = 4'd10;
    localparam logic [3:0] MAX_DIGIT      = 4'd9;
    localparam logic [3:0] MAX_MS_HR      = 4'd2;
    localparam logic [3:0] MAX_LS_HR_TOP  = 4'd3;   // hours units limit when tens is 2
    localparam logic [3:0] MAX_MS_MIN     = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ENTRY      = 2'd1,
        ST_ALARM_VIEW = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= MAX_DIGIT);
    endfunction

    function automatic logic is_valid_time(input logic [3:0] ms_hr,
                                           input logic [3:0] ls_hr,
                                           input logic [3:0] ms_min,
                                           input logic [3:0] ls_min);
        logic hr_ok;
        logic min_ok;
        if (ms_hr < MAX_MS_HR) begin
            hr_ok = (ls_hr <= MAX_DIGIT);
        end else if (ms_hr == MAX_MS_HR) begin
            hr_ok = (ls_hr <= MAX_LS_HR_TOP);
        end else begin
            hr_ok = 1'b0;
        end
        min_ok = (ms_min <= MAX_MS_MIN) && (ls_min <= MAX_DIGIT);
        return hr_ok && min_ok;
    endfunction

endpackage

// File: rtl/aclk_keyreg.sv
// -----------------------------------------------------------------------------
// aclk_keyreg
// Four-nibble key register. A first digit clears the register and lands in the
// minutes-units position; later digits shift everything one place left.
// Ports:
//   clock, reset        rising-edge clock, async active-high clear
//   load_first          load {0,0,0,digit}
//   shift               shift left by one digit, digit enters on the right
//   digit[3:0]          digit to load/shift in
//   ms_hr .. ls_min     registered digits (hours tens .. minutes units)
// -----------------------------------------------------------------------------
module aclk_keyreg (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_first,
    input  logic       shift,
    input  logic [3:0] digit,
    output logic [3:0] ms_hr,
    output logic [3:0] ls_hr,
    output logic [3:0] ms_min,
    output logic [3:0] ls_min
);

    // Digit storage: load_first takes priority; otherwise shift or hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ms_hr  <= 4'd0;
            ls_hr  <= 4'd0;
            ms_min <= 4'd0;
            ls_min <= 4'd0;
        end else if (load_first) begin
            ms_hr  <= 4'd0;
            ls_hr  <= 4'd0;
            ms_min <= 4'd0;
            ls_min <= digit;
        end else if (shift) begin
            ms_hr  <= ls_hr;
            ls_hr  <= ms_min;
            ms_min <= ls_min;
            ls_min <= digit;
        end else begin
            ms_hr  <= ms_hr;
            ls_hr  <= ls_hr;
            ms_min <= ms_min;
            ls_min <= ls_min;
        end
    end

endmodule

// File: rtl/aclk_key_entry.sv
// -----------------------------------------------------------------------------
// aclk_key_entry
// Keypad front end of the alarm clock. Accepts one digit per key press, builds
// a four-digit HH:MM value, and on a button press either strobes it into the
// alarm register / current-time counter or flags an invalid entry. An entry
// with no new digit for TIMEOUT_TICKS one_second ticks is abandoned.
// Parameters:
//   TIMEOUT_TICKS   one_second ticks before an idle entry is dropped (1..255)
// Ports:
//   clock, reset            rising-edge clock, async active-high clear
//   one_second              one-cycle tick, once per second
//   key[3:0]                keypad code, 0-9 digit, 10..15 no key
//   alarm_button            store alarm (in entry) / view alarm (in idle)
//   time_button             store current time (in entry)
//   key_ms_hr .. key_ls_min key register digits to the display
//   show_new_time, show_a   display select (entry / alarm view)
//   load_new_a, load_new_c  one-cycle store strobes
//   entry_error             one-cycle strobe, store of an invalid time
// -----------------------------------------------------------------------------
module aclk_key_entry #(
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic [3:0] key_ms_hr,
    output logic [3:0] key_ls_hr,
    output logic [3:0] key_ms_min,
    output logic [3:0] key_ls_min,
    output logic       show_new_time,
    output logic       show_a,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       entry_error
);

    import aclk_pkg::*;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_TICKS);
    localparam logic [7:0] COUNT_MAX     = 8'hFF;

    logic [3:0] key_norm_s;
    logic [3:0] prev_key_r;
    logic       accept_s;
    logic       load_first_s;
    logic       shift_s;
    logic       time_valid_s;
    state_t     state_r;
    logic [7:0] tick_count_r;

    // Fold the unused codes 11-15 onto NOKEY and detect a fresh press.
    always_comb begin
        key_norm_s = NOKEY;
        if (is_digit(key)) begin
            key_norm_s = key;
        end else begin
            key_norm_s = NOKEY;
        end
        // A digit counts only when the previous cycle saw no key, so a held
        // key or a direct digit-to-digit roll-over is never accepted.
        accept_s = (key_norm_s != NOKEY) && (prev_key_r == NOKEY);
    end

    // Previous-cycle key for press detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_key_r <= NOKEY;
        end else begin
            prev_key_r <= key_norm_s;
        end
    end

    // Key register controls; any button in ENTRY blocks the shift.
    always_comb begin
        load_first_s = 1'b0;
        shift_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_first_s = accept_s;
            end
            ST_ENTRY: begin
                shift_s = accept_s && !alarm_button && !time_button;
            end
            default: begin
                load_first_s = 1'b0;
                shift_s      = 1'b0;
            end
        endcase
    end

    aclk_keyreg u_keyreg (
        .clock      (clock),
        .reset      (reset),
        .load_first (load_first_s),
        .shift      (shift_s),
        .digit      (key_norm_s),
        .ms_hr      (key_ms_hr),
        .ls_hr      (key_ls_hr),
        .ms_min     (key_ms_min),
        .ls_min     (key_ls_min)
    );

    // Range check of the value currently held in the key register.
    always_comb begin
        time_valid_s = is_valid_time(key_ms_hr, key_ls_hr, key_ms_min, key_ls_min);
    end

    // Entry FSM with inactivity counter; display selects and strobes are
    // registered alongside the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            tick_count_r  <= 8'd0;
            show_new_time <= 1'b0;
            show_a        <= 1'b0;
            load_new_a    <= 1'b0;
            load_new_c    <= 1'b0;
            entry_error   <= 1'b0;
        end else begin
            load_new_a  <= 1'b0;
            load_new_c  <= 1'b0;
            entry_error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tick_count_r <= 8'd0;
                    if (accept_s) begin
                        state_r       <= ST_ENTRY;
                        show_new_time <= 1'b1;
                        show_a        <= 1'b0;
                    end else if (alarm_button) begin
                        state_r       <= ST_ALARM_VIEW;
                        show_new_time <= 1'b0;
                        show_a        <= 1'b1;
                    end else begin
                        state_r       <= ST_IDLE;
                        show_new_time <= 1'b0;
                        show_a        <= 1'b0;
                    end
                end
                ST_ENTRY: begin
                    show_a <= 1'b0;
                    if (alarm_button && time_button) begin
                        entry_error   <= 1'b1;
                        state_r       <= ST_IDLE;
                        tick_count_r  <= 8'd0;
                        show_new_time <= 1'b0;
                    end else if (alarm_button) begin
                        load_new_a    <= time_valid_s;
                        entry_error   <= !time_valid_s;
                        state_r       <= ST_IDLE;
                        tick_count_r  <= 8'd0;
                        show_new_time <= 1'b0;
                    end else if (time_button) begin
                        load_new_c    <= time_valid_s;
                        entry_error   <= !time_valid_s;
                        state_r       <= ST_IDLE;
                        tick_count_r  <= 8'd0;
                        show_new_time <= 1'b0;
                    end else if (accept_s) begin
                        // A digit on a tick cycle still restarts the timeout.
                        tick_count_r  <= 8'd0;
                        show_new_time <= 1'b1;
                    end else if (one_second) begin
                        if (tick_count_r >= (TIMEOUT_LIMIT - 8'd1)) begin
                            state_r       <= ST_IDLE;
                            tick_count_r  <= 8'd0;
                            show_new_time <= 1'b0;
                        end else begin
                            if (tick_count_r != COUNT_MAX) begin
                                tick_count_r <= tick_count_r + 8'd1;
                            end else begin
                                tick_count_r <= tick_count_r;
                            end
                            show_new_time <= 1'b1;
                        end
                    end else begin
                        show_new_time <= 1'b1;
                    end
                end
                ST_ALARM_VIEW: begin
                    tick_count_r  <= 8'd0;
                    show_new_time <= 1'b0;
                    if (alarm_button) begin
                        state_r <= ST_ALARM_VIEW;
                        show_a  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        show_a  <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    tick_count_r  <= 8'd0;
                    show_new_time <= 1'b0;
                    show_a        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aclk_key_entry.md
Name: aclk_key_entry

Overview:
- Producer end of the display interface: scans the keypad, shifts entered digits into a 4-digit key register, and drives the key digits and display-select controls that the LCD display block consumes.
- Validates an entered time and issues one-cycle load strobes to the alarm register and the current-time counter.
- Abandons an entry after a programmable inactivity timeout.

Parameters:
TIMEOUT_TICKS, 10, number of one_second ticks without a new digit before an entry is abandoned (range 1..255)

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state
one_second  input  1  one-cycle pulse, once per second
key  input  4  keypad code: 0-9 digit, 10 (NOKEY) none pressed; 11-15 treated as NOKEY
alarm_button  input  1  level; store-alarm / view-alarm button
time_button  input  1  level; store-current-time button
key_ms_hr  output  4  key register, hours tens digit
key_ls_hr  output  4  key register, hours units digit
key_ms_min  output  4  key register, minutes tens digit
key_ls_min  output  4  key register, minutes units digit
show_new_time  output  1  display selects key register
show_a  output  1  display selects alarm time
load_new_a  output  1  one-cycle strobe: key register -> alarm register
load_new_c  output  1  one-cycle strobe: key register -> current time
entry_error  output  1  one-cycle strobe: store attempted with an invalid time

Behaviour:
- All outputs registered.
- Reset value of every output is 0; FSM resets to IDLE; timeout counter resets to 0; previous-key register resets to NOKEY.
- Key acceptance:
  - Digit accepted in the cycle when sampled key is 0-9 and the previous-cycle key was NOKEY (one digit per press).
  - A held key is not repeated.
  - Key changing directly digit->digit is not accepted.
- Shift on accept: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=digit. Visible on outputs the cycle after acceptance.
- Validity check on key register contents:
  - ms_hr<=2; ls_hr<=9; if ms_hr==2 then ls_hr<=3.
  - ms_min<=5; ls_min<=9.
- FSM states: IDLE, ENTRY, ALARM_VIEW.
  - IDLE:
    - Accepted digit -> ENTRY; register loads {0,0,0,digit} (not shifted); counter cleared.
    - Else alarm_button=1 -> ALARM_VIEW.
    - time_button ignored.
  - ENTRY:
    - Priority 1, both buttons high: entry_error pulse, -> IDLE, no load.
    - Priority 2, alarm_button: if valid, load_new_a pulse, else entry_error pulse; -> IDLE.
    - Priority 3, time_button: if valid, load_new_c pulse, else entry_error pulse; -> IDLE.
    - Priority 4, accepted digit: shift, counter <- 0.
    - Priority 5, one_second: counter+1; reaching TIMEOUT_TICKS -> IDLE, counter <- 0, no strobe.
    - A digit and a button in the same cycle: button wins; the digit is discarded and the register is not shifted.
    - A digit and one_second in the same cycle: the digit wins and the counter is cleared.
  - ALARM_VIEW: stays while alarm_button=1; -> IDLE on release. Digits ignored.
- Output decode (registered from next state):
  - show_new_time=1 iff state ENTRY.
  - show_a=1 iff state ALARM_VIEW.
  - Never both 1.
- Strobes:
  - Asserted exactly one cycle, the cycle after the button is sampled in ENTRY.
  - Key digits are stable during and after the strobe.
  - The key register retains its value in IDLE until the next first digit.
- Button held across the return to IDLE: no re-trigger. IDLE needs a new digit before any store. A held alarm_button enters ALARM_VIEW on the cycle after the strobe.
- Reset mid-entry: immediate return to IDLE, register cleared, no strobe.
- Counter width: 8 bits; saturates, never wraps.

Decomposition:
- Shared package aclk_pkg:
  - NOKEY = 4'd10.
  - State encoding: IDLE, ENTRY, ALARM_VIEW.
  - Time limits: 2, 3, 5, 9.
  - Validity function is_valid_time(ms_hr, ls_hr, ms_min, ls_min).
- One sub-module aclk_keyreg: 4-nibble register with clear-and-load-first and shift-on-accept controls.
- FSM, edge detect and timeout stay in aclk_key_entry.

Test Plan:
- Keys 1,2,3,0 each pressed/released, then time_button -> key digits 1,2,3,0; show_new_time=1 during entry; load_new_c one cycle; then show_new_time=0.
- Keys 2,5,0,0 then alarm_button -> entry_error one cycle, no load_new_a, state IDLE; keys 0,6,4,5 + alarm_button -> load_new_a, digits 0,6,4,5.
- Key 7 held 20 cycles -> exactly one shift; key 3->7 without NOKEY between -> no accept.
- Key 4 then 10 one_second pulses with no digit (TIMEOUT_TICKS=10) -> IDLE after 10th; no strobe; a digit on the 10th tick cycle instead clears the counter.
- IDLE, alarm_button held 5 cycles -> show_a=1 cycles 2-6, then 0; digits during the hold ignored; both buttons in ENTRY -> entry_error only.
- Reset asserted mid-entry after 2 digits -> all outputs 0 asynchronously, IDLE, no strobe after release.
